// File: rtl/dino_input_ctrl.sv
// dino_input_ctrl: sits between the button debouncers and the game core.
// It runs the shared debounce prescaler and turns the debounced jump and duck
// levels into a jump request/acknowledge handshake and a duck level. Jump has
// priority over duck. It also handles the game-over / restart sequence, so the
// core only ever sees one clean action at a time.
//
// Handshake: jump_req is the valid signal and jump_ack is the ready signal.
// jump_req rises one cycle after a jump_db rising edge, provided the FSM is in
// IDLE or DUCK and the dino is grounded. It then stays high, with no timeout,
// until jump_ack is sampled high. It drops in the following cycle. jump_ack
// has no effect in any other cycle. Reset or game_over withdraws the request
// without an ack.
module dino_input_ctrl #(
  parameter int TICK_DIV = 1000,
  parameter int TICK_W   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       jump_db,
  input  logic       duck_db,
  input  logic       airborne,
  input  logic       game_over,
  input  logic       jump_ack,
  output logic       debounce_tick,
  output logic       jump_req,
  output logic       duck,
  output logic       restart,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_JREQ = 3'd1,
    ST_AIR  = 3'd2,
    ST_DUCK = 3'd3,
    ST_OVER = 3'd4
  } state_e;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              jump_q;
  logic              jump_rise;
  state_e            state_q, state_d;
  logic              air_armed_q, air_armed_d;
  logic              restart_q, restart_d;

  // Free-running prescaler: counts 0..TICK_DIV-1 and wraps, in every FSM state.
  always_comb begin
    tick_cnt_d = tick_cnt_q + TICK_W'(1);
    if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign debounce_tick = (tick_cnt_q == TICK_LAST);

  // Delayed copy of the jump level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      jump_q <= 1'b0;
    end else begin
      jump_q <= jump_db;
    end
  end

  // Only a fresh press starts a jump. A held button never re-requests.
  assign jump_rise = jump_db & ~jump_q;

  // Next-state logic. OVER handles its own exit. In every other state,
  // game_over overrides all normal transitions.
  always_comb begin
    state_d   = state_q;
    restart_d = 1'b0;
    if (state_q == ST_OVER) begin
      if (!game_over) begin
        state_d = ST_IDLE;
      end else if (jump_rise) begin
        state_d   = ST_IDLE;
        restart_d = 1'b1;
      end
    end else if (game_over) begin
      state_d = ST_OVER;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (jump_rise && !airborne) begin
            state_d = ST_JREQ;
          end else if (duck_db) begin
            state_d = ST_DUCK;
          end
        end
        ST_JREQ: begin
          if (jump_ack) begin
            state_d = ST_AIR;
          end
        end
        ST_AIR: begin
          // Physics may raise airborne late, so ignore the landing check
          // until the dino has spent one full cycle in AIR.
          if (air_armed_q && !airborne) begin
            state_d = duck_db ? ST_DUCK : ST_IDLE;
          end
        end
        ST_DUCK: begin
          if (jump_rise && !airborne) begin
            state_d = ST_JREQ;
          end else if (!duck_db) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    air_armed_d = (state_q == ST_AIR) && (state_d == ST_AIR);
  end

  // State, AIR landing-arm flag and registered restart pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      air_armed_q <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      air_armed_q <= air_armed_d;
      restart_q   <= restart_d;
    end
  end

  assign jump_req    = (state_q == ST_JREQ);
  assign duck        = (state_q == ST_DUCK);
  assign restart     = restart_q;
  assign dbg_state_o = state_q;

  // Actions seen by the game core are mutually exclusive.
  a_excl: assert property (@(posedge clk) disable iff (rst) !(jump_req && duck));

  // A restart pulse always lands in IDLE, so it can never repeat back to back.
  a_restart_pulse: assert property (@(posedge clk) disable iff (rst) restart |=> !restart);

endmodule

// File: tb/tb_dino_input_ctrl.sv
// Bench for dino_input_ctrl with a short prescaler period (TICK_DIV=4).
module tb_dino_input_ctrl;

  localparam int TICK_DIV = 4;
  localparam int TICK_W   = 3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_JREQ = 3'd1;
  localparam logic [2:0] S_AIR  = 3'd2;
  localparam logic [2:0] S_DUCK = 3'd3;
  localparam logic [2:0] S_OVER = 3'd4;

  localparam int W = 6;

  logic       clk;
  logic       rst;
  logic       jump_db, duck_db, airborne, game_over, jump_ack;
  logic       debounce_tick, jump_req, duck, restart;
  logic [2:0] dbg_state;

  int n_vec;
  int n_err;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic       jd, dd, air, go, ack;
    logic       jr, dk, rs;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  dino_input_ctrl #(.TICK_DIV(TICK_DIV), .TICK_W(TICK_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_db      (jump_db),
    .duck_db      (duck_db),
    .airborne     (airborne),
    .game_over    (game_over),
    .jump_ack     (jump_ack),
    .debounce_tick(debounce_tick),
    .jump_req     (jump_req),
    .duck         (duck),
    .restart      (restart),
    .dbg_state_o  (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic jd, dd, air, go, ack, jr, dk, rs,
                              input logic [2:0] st);
    vec_t v;
    v.jd = jd; v.dd = dd; v.air = air; v.go = go; v.ack = ack;
    v.jr = jr; v.dk = dk; v.rs = rs; v.st = st;
    return v;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  // Pops one expected record and compares it to the sampled outputs.
  task automatic check_outs(input string name);
    logic [W-1:0] exp;
    logic [W-1:0] act;
    exp = exp_q.pop_front();
    act = {jump_req, duck, restart, dbg_state};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got jr=%0b dk=%0b rs=%0b st=%0d, expected jr=%0b dk=%0b rs=%0b st=%0d",
               name, act[5], act[4], act[3], act[2:0], exp[5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic drive(input logic jd, dd, air, go, ack);
    jump_db = jd; duck_db = dd; airborne = air; game_over = go; jump_ack = ack;
  endtask

  // Applies reset for one edge and releases it #1 later. Checks the reset state.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 1'b0, S_IDLE});
    check_outs({tag, "_outs"});
    check_bit({tag, "_tick0"}, debounce_tick, 1'b0);
  endtask

  // Checks debounce_tick for n edges after a reset edge: high only when the
  // edge count is 3 mod 4.
  task automatic check_ticks(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      check_bit($sformatf("%s_tick%0d", tag, k), debounce_tick, (k % TICK_DIV) == TICK_DIV - 1);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    drive(0, 0, 0, 0, 0);

    // Prescaler: ticks at cycles 4, 8, 12, ... after release, over 100+ periods.
    do_reset("rst0");
    check_ticks("presc", 420);

    // Vector table. Inputs are held for one cycle, and the outputs are checked
    // right after that cycle's edge.
    //         jd dd ai go ak  jr dk rs state
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));  // 0 idle
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, S_JREQ));  // 1 rise -> req next cycle
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, S_JREQ));  // 2 no ack, held
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, S_JREQ));  // 3
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, S_JREQ));  // 4
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, S_AIR));   // 5 ack -> req drops
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, S_AIR));   // 6
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, S_AIR));   // 7
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, S_IDLE));  // 8 land
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, S_IDLE));  // 9 held button: no re-request
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));  // 10
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, S_JREQ));  // 11 jump beats duck
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, S_AIR));   // 12
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, S_AIR));   // 13 entry cycle ignores airborne=0
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, S_DUCK));  // 14 land with duck held
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, S_DUCK));  // 15
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, S_JREQ));  // 16 jump from duck
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, S_AIR));   // 17
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, S_AIR));   // 18
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));  // 19 land, no duck
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, S_IDLE));  // 20
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, S_IDLE));  // 21 airborne blocks jump
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, S_DUCK));  // 22 duck instead
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, S_IDLE));  // 23 duck release
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, S_IDLE));  // 24 stray ack ignored
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, S_JREQ));  // 25
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, S_OVER));  // 26 game over withdraws req
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, S_OVER));  // 27
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, S_IDLE));  // 28 restart pulse
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, S_OVER));  // 29 re-enter OVER
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, S_OVER));  // 30 held: no second restart
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, S_OVER));  // 31
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, S_IDLE));  // 32 new rise restarts
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, S_IDLE));  // 33
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, S_OVER));  // 34
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, S_IDLE));  // 35 game_over low: exit, no restart
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));  // 36
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, S_DUCK));  // 37
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, S_OVER));  // 38 game over from duck
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, S_IDLE));  // 39
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, S_DUCK));  // 40
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));  // 41
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, S_JREQ));  // 42
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, S_AIR));   // 43
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, S_OVER));  // 44 game over while airborne
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE));  // 45

    do_reset("rst1");
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].jd, vecs[i].dd, vecs[i].air, vecs[i].go, vecs[i].ack);
      exp_q.push_back({vecs[i].jr, vecs[i].dk, vecs[i].rs, vecs[i].st});
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i));
    end

    // Reset while in DUCK: outputs clear and the prescaler restarts from 0.
    drive(0, 1, 0, 0, 0);
    exp_q.push_back({1'b0, 1'b1, 1'b0, S_DUCK});
    @(posedge clk);
    #1;
    check_outs("duck_pre");
    drive(0, 0, 0, 0, 0);
    do_reset("rst_duck");
    check_ticks("duck_presc", 6);

    // Reset while in JREQ: the request drops with no ack.
    drive(1, 0, 0, 0, 0);
    exp_q.push_back({1'b1, 1'b0, 1'b0, S_JREQ});
    @(posedge clk);
    #1;
    check_outs("jreq_pre");
    drive(0, 0, 0, 0, 0);
    do_reset("rst_jreq");
    check_ticks("jreq_presc", 6);

    // Restart pulse cleared by a reset in the same cycle.
    drive(0, 0, 0, 1, 0);
    exp_q.push_back({1'b0, 1'b0, 1'b0, S_OVER});
    @(posedge clk);
    #1;
    check_outs("over_pre");
    drive(1, 0, 0, 1, 0);
    do_reset("rst_over");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
